// File: rtl/enc_seq_1553_if.sv
// Signal bundle linking the 1553 transmit sequencer to its word memory, the encoder and its controller.
// The master modport is the sequencer itself; the slave modport is the surrounding system.
interface enc_seq_1553_if #(
    parameter int AW    = 9,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      word_cnt;
    logic [GAP_W-1:0] gap;
    logic             loop;
    logic             mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [17:0]      mem_data;
    logic             enc_busy;
    logic [15:0]      tx_dword;
    logic             tx_csw;
    logic             tx_dw;
    logic             seq_busy;
    logic             done;
    logic             ack_err;
    logic [AW:0]      words_sent;

    modport master (
        input  start, abort, base_addr, word_cnt, gap, loop, mem_data, enc_busy,
        output mem_rd, mem_addr, tx_dword, tx_csw, tx_dw, seq_busy, done, ack_err, words_sent
    );

    modport slave (
        output start, abort, base_addr, word_cnt, gap, loop, mem_data, enc_busy,
        input  mem_rd, mem_addr, tx_dword, tx_csw, tx_dw, seq_busy, done, ack_err, words_sent
    );
endinterface

// File: rtl/enc_seq_1553.sv
// Table-driven transmit sequencer: fetches {csw,dw,dword} entries from a synchronous memory
// and issues one encoder write per entry, paced by enc_busy and a programmable gap.
module enc_seq_1553 #(
    parameter int AW     = 9,
    parameter int GAP_W  = 4,
    parameter int ACK_TO = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    enc_seq_1553_if.master bus
);
    localparam int ACK_W = $clog2(ACK_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_END
    } state_t;

    state_t           state_q, state_d, after_word;
    logic [AW-1:0]    base_q;
    logic [AW:0]      cnt_q, idx_q, sent_q, idx_inc;
    logic [GAP_W-1:0] gap_q, gap_cnt_q;
    logic [ACK_W-1:0] ack_cnt_q;
    logic [15:0]      data_q;
    logic             csw_q, dw_q;
    logic             ld_cfg, clr_pass, inc_idx, ld_data, inc_sent, ld_gap;

    assign idx_inc        = idx_q + 1'b1;
    assign bus.mem_addr   = base_q + idx_q[AW-1:0];
    assign bus.seq_busy   = (state_q != S_IDLE);
    assign bus.words_sent = sent_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        ld_cfg      = 1'b0;
        clr_pass    = 1'b0;
        inc_idx     = 1'b0;
        ld_data     = 1'b0;
        inc_sent    = 1'b0;
        ld_gap      = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.tx_csw  = 1'b0;
        bus.tx_dw   = 1'b0;
        bus.done    = 1'b0;
        bus.ack_err = 1'b0;

        // Where to go once an entry is finished (sent or skipped); gap=0 bypasses GAP entirely.
        if (gap_q != '0)          after_word = S_GAP;
        else if (idx_inc < cnt_q) after_word = S_FETCH;
        else                      after_word = S_END;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ld_cfg  = 1'b1;
                    state_d = (bus.word_cnt == '0) ? S_END : S_FETCH;
                end
            end
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                ld_data = 1'b1;
                if (bus.mem_data[17:16] == 2'b00) begin
                    inc_idx = 1'b1;
                    ld_gap  = (after_word == S_GAP);
                    state_d = after_word;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.tx_csw = csw_q;
                bus.tx_dw  = dw_q;
                inc_sent   = 1'b1;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.enc_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
                    bus.ack_err = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.enc_busy) begin
                    inc_idx = 1'b1;
                    ld_gap  = (after_word == S_GAP);
                    state_d = after_word;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) state_d = (idx_q < cnt_q) ? S_FETCH : S_END;
            end
            S_END: begin
                bus.done = 1'b1;
                // An empty pass never loops, otherwise loop mode would fetch entries it was told not to.
                if (bus.loop && cnt_q != '0) begin
                    clr_pass = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition and squashes all strobes of this cycle.
        if (bus.abort) begin
            state_d     = S_IDLE;
            ld_cfg      = 1'b0;
            clr_pass    = 1'b0;
            inc_idx     = 1'b0;
            ld_data     = 1'b0;
            inc_sent    = 1'b0;
            ld_gap      = 1'b0;
            bus.mem_rd  = 1'b0;
            bus.tx_csw  = 1'b0;
            bus.tx_dw   = 1'b0;
            bus.done    = 1'b0;
            bus.ack_err = 1'b0;
        end

        bus.tx_dword = (bus.tx_csw || bus.tx_dw) ? data_q : 16'h0000;
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            sent_q    <= '0;
            gap_cnt_q <= '0;
            ack_cnt_q <= '0;
            data_q    <= '0;
            csw_q     <= 1'b0;
            dw_q      <= 1'b0;
        end else begin
            if (ld_cfg) begin
                base_q <= bus.base_addr;
                cnt_q  <= bus.word_cnt;
                gap_q  <= bus.gap;
            end
            if (ld_cfg || clr_pass) begin
                idx_q  <= '0;
                sent_q <= '0;
            end
            if (inc_idx)  idx_q  <= idx_inc;
            if (inc_sent) sent_q <= sent_q + 1'b1;
            if (ld_data) begin
                data_q <= bus.mem_data[15:0];
                csw_q  <= bus.mem_data[17];
                dw_q   <= bus.mem_data[16] & ~bus.mem_data[17];
            end
            if (ld_gap)                gap_cnt_q <= gap_q - 1'b1;
            else if (state_q == S_GAP) gap_cnt_q <= gap_cnt_q - 1'b1;
            if (state_q == S_WAIT_ACK) ack_cnt_q <= ack_cnt_q + 1'b1;
            else                       ack_cnt_q <= '0;
        end
    end
endmodule

// File: tb/tb_enc_seq_1553.sv
// Scoreboard bench for enc_seq_1553: a table model predicts the write stream per pass,
// a negedge monitor compares DUT writes, done pulses and timing against those predictions.
module tb_enc_seq_1553;
    localparam int AW     = 9;
    localparam int GAP_W  = 4;
    localparam int ACK_TO = 4;
    localparam int DEPTH  = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    enc_seq_1553_if #(.AW(AW), .GAP_W(GAP_W)) bus ();

    enc_seq_1553 #(.AW(AW), .GAP_W(GAP_W), .ACK_TO(ACK_TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: synchronous read, data valid the cycle after mem_rd.
    logic [17:0] mem [DEPTH];
    logic [17:0] rd_q = '0;
    always @(posedge clk) if (bus.mem_rd) rd_q <= mem[bus.mem_addr];
    assign bus.mem_data = rd_q;

    // Encoder: busy for frame_len cycles starting the cycle after a write pulse.
    int   frame_len = 4;
    logic enc_dead  = 1'b0;
    int   busy_left;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left    <= 0;
            bus.enc_busy <= 1'b0;
        end else if (!enc_dead && (bus.tx_csw || bus.tx_dw)) begin
            busy_left    <= frame_len;
            bus.enc_busy <= 1'b1;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left    <= 0;
            bus.enc_busy <= 1'b0;
        end
    end

    // Scoreboard state
    logic [17:0] exp_q[$];
    int          exp_done[$];
    int          rd_addr[$], rd_cyc[$], fall_cyc[$], pulse_cyc[$];
    int          done_cnt = 0, ack_seen = 0, ack_cyc = 0, start_cyc = 0;
    logic        ack_ok = 1'b0, prev_busy = 1'b0;

    // Reference: one pass walks word_cnt table entries, dropping empty ones, csw beating dw.
    task automatic push_pass(input int base, input int cnt, input bit with_done, output int n);
        logic [17:0] e;
        n = 0;
        for (int i = 0; i < cnt; i++) begin
            e = mem[(base + i) % DEPTH];
            if (e[17])      begin exp_q.push_back({2'b10, e[15:0]}); n++; end
            else if (e[16]) begin exp_q.push_back({2'b01, e[15:0]}); n++; end
        end
        if (with_done) exp_done.push_back(n);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_rd) begin
                rd_addr.push_back(int'(bus.mem_addr));
                rd_cyc.push_back(cyc);
            end
            if (prev_busy && !bus.enc_busy) fall_cyc.push_back(cyc);
            prev_busy = bus.enc_busy;
            if (bus.tx_csw || bus.tx_dw) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("write_unexpected", {bus.tx_csw, bus.tx_dw, bus.tx_dword}, 0);
                else check("write", {bus.tx_csw, bus.tx_dw, bus.tx_dword}, exp_q.pop_front());
            end else if (bus.tx_dword != 16'h0) begin
                check("tx_dword_idle", bus.tx_dword, 0);
            end
            if (bus.done) begin
                done_cnt++;
                if (exp_done.size() == 0) check("done_unexpected", bus.done, 0);
                else check("done_words", bus.words_sent, exp_done.pop_front());
            end
            if (bus.ack_err) begin
                ack_seen++;
                ack_cyc = cyc;
                if (!ack_ok) check("ack_err_unexpected", bus.ack_err, 0);
            end
        end
    end

    task automatic clear_logs();
        rd_addr.delete();
        rd_cyc.delete();
        fall_cyc.delete();
        pulse_cyc.delete();
    endtask

    // Issue a start pulse, then scramble the config inputs to show they are not live.
    task automatic run(input int base, input int cnt, input int g, input bit lp);
        @(posedge clk); #1;
        bus.base_addr = AW'(base);
        bus.word_cnt  = (AW + 1)'(cnt);
        bus.gap       = GAP_W'(g);
        bus.loop      = lp;
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.word_cnt  = (AW + 1)'($urandom);
        bus.gap       = GAP_W'($urandom);
    endtask

    task automatic wait_done(input string name, input int target);
        int b = 0;
        while (done_cnt < target && b < 2000) begin
            @(posedge clk); #1;
            b++;
        end
        check(name, done_cnt >= target, 1);
    endtask

    int n, d0, d1, a0, b, base, cnt, g;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.loop = 1'b0;
        bus.base_addr = '0; bus.word_cnt = '0; bus.gap = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seq_busy", bus.seq_busy, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_tx_pulse", {bus.tx_csw, bus.tx_dw}, 0);
        check("rst_tx_dword", bus.tx_dword, 0);
        check("rst_done_ack", {bus.done, bus.ack_err}, 0);
        check("rst_words_sent", bus.words_sent, 0);
        rst_n = 1'b1;

        // Three-word table: order, latency start->pulse, single done
        mem[0] = {2'b10, 16'h5555};
        mem[1] = {2'b01, 16'hABCD};
        mem[2] = {2'b01, 16'h1234};
        clear_logs();
        d0 = done_cnt;
        push_pass(0, 3, 1, n);
        run(0, 3, 0, 0);
        wait_done("a_done_seen", d0 + 1);
        check("a_pulse_count", pulse_cyc.size(), 3);
        if (pulse_cyc.size() > 0) check("a_start_to_pulse", pulse_cyc[0] - start_cyc, 3);
        check("a_done_count", done_cnt - d0, 1);
        check("a_words_sent", bus.words_sent, 3);
        check("a_idle_after", bus.seq_busy, 0);

        // Gap of 5: next fetch follows busy fall by gap+1 cycles
        mem[0] = {2'b01, 16'h0A0A};
        mem[1] = {2'b01, 16'h0B0B};
        clear_logs();
        d0 = done_cnt;
        push_pass(0, 2, 1, n);
        run(0, 2, 5, 0);
        wait_done("b_done_seen", d0 + 1);
        check("b_fetches", rd_cyc.size(), 2);
        if (rd_cyc.size() == 2 && fall_cyc.size() > 0)
            check("b_gap_spacing", rd_cyc[1] - fall_cyc[0], 6);

        // Address wrap at the top of memory
        mem[510] = {2'b10, 16'h0510};
        mem[511] = {2'b01, 16'h0511};
        mem[0]   = {2'b01, 16'h0000};
        mem[1]   = {2'b10, 16'h0001};
        clear_logs();
        d0 = done_cnt;
        push_pass(510, 4, 1, n);
        run(510, 4, 0, 0);
        wait_done("c_done_seen", d0 + 1);
        check("c_fetches", rd_addr.size(), 4);
        if (rd_addr.size() == 4) begin
            check("c_addr0", rd_addr[0], 510);
            check("c_addr1", rd_addr[1], 511);
            check("c_addr2", rd_addr[2], 0);
            check("c_addr3", rd_addr[3], 1);
        end

        // Empty entry is skipped, csw+dw entry goes out as csw
        mem[20] = {2'b00, 16'hFFFF};
        mem[21] = {2'b11, 16'h0F0F};
        mem[22] = {2'b01, 16'h7777};
        clear_logs();
        d0 = done_cnt;
        push_pass(20, 3, 1, n);
        run(20, 3, 0, 0);
        wait_done("d_done_seen", d0 + 1);
        check("d_fetches", rd_addr.size(), 3);
        check("d_words_sent", bus.words_sent, 2);

        // Empty pass: done with no memory read
        clear_logs();
        d0 = done_cnt;
        push_pass(0, 0, 1, n);
        run(0, 0, 0, 0);
        wait_done("e_done_seen", d0 + 1);
        check("e_no_fetch", rd_addr.size(), 0);
        check("e_words_sent", bus.words_sent, 0);

        // Encoder never acknowledges: ack_err, back to idle, no done
        enc_dead = 1'b1;
        ack_ok   = 1'b1;
        mem[30]  = {2'b01, 16'h4242};
        clear_logs();
        d0 = done_cnt;
        a0 = ack_seen;
        push_pass(30, 1, 0, n);
        run(30, 1, 0, 0);
        b = 0;
        while (ack_seen == a0 && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        check("f_ack_seen", ack_seen - a0, 1);
        if (pulse_cyc.size() > 0) check("f_ack_latency", ack_cyc - pulse_cyc[0], ACK_TO);
        check("f_seq_idle", bus.seq_busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("f_no_done", done_cnt - d0, 0);
        enc_dead = 1'b0;
        ack_ok   = 1'b0;

        // Loop mode: done every 2 words; abort while the encoder is busy
        frame_len = 5;
        mem[40] = {2'b01, 16'h1111};
        mem[41] = {2'b10, 16'h2222};
        for (int p = 0; p < 4; p++) push_pass(40, 2, 1, n);
        d0 = done_cnt;
        run(40, 2, 1, 1);
        wait_done("g_three_passes", d0 + 3);
        b = 0;
        while (!bus.enc_busy && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        check("g_busy_seen", bus.enc_busy, 1);
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.loop  = 1'b0;
        check("g_abort_idle", bus.seq_busy, 0);
        check("g_pass_count", done_cnt - d0, 3);
        exp_q.delete();
        exp_done.delete();
        d1 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("g_no_done_after_abort", done_cnt - d1, 0);

        // Randomised tables against the model
        for (int t = 0; t < 8; t++) begin
            frame_len = $urandom_range(2, 6);
            base      = $urandom_range(0, DEPTH - 1);
            cnt       = $urandom_range(1, 6);
            g         = $urandom_range(0, 3);
            for (int i = 0; i < cnt; i++) mem[(base + i) % DEPTH] = 18'($urandom);
            d0 = done_cnt;
            push_pass(base, cnt, 1, n);
            run(base, cnt, g, 0);
            wait_done("r_done_seen", d0 + 1);
            check("r_words_sent", bus.words_sent, n);
            check("r_queue_drained", exp_q.size(), 0);
        end

        check("end_done_queue", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
